fdiv_seq: RTL

//  Iterative single-precision divider, companion to the FMUL multiplier in the FPU datapath.

---
 rtl/fdiv_seq.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/fdiv_seq.sv
`timescale 1ns/1ps
// Purpose : iterative single-precision divider (restoring, one quotient bit per clock), FMUL-compatible result format.
// Latency : normal operands 26 cycles from the start edge to done; special operands (zero/inf/NaN) 1 cycle.
// Backpressure: none; start is sampled only while busy=0, so a request during an operation is dropped.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               operation request, sampled in IDLE only
//   A_sign/A_exp/A_frac dividend (unpacked, hidden bit implied)
//   B_sign/B_exp/B_frac divisor  (unpacked, hidden bit implied)
//   busy                operation in flight (DIV or NORM)
//   done                one-cycle pulse, result outputs valid
//   sign/exp/frac       quotient, frac[23] is the hidden bit; held until next result
//   error               invalid operation (NaN result)
//   overflow            exponent overflow, result forced to Inf
//   div_by_zero         finite nonzero divided by zero
module fdiv_seq #(
   parameter int EXP_BIAS = 127,
   parameter int EXP_MAX  = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        A_sign,
   input  logic [7:0]  A_exp,
   input  logic [22:0] A_frac,
   input  logic        B_sign,
   input  logic [7:0]  B_exp,
   input  logic [22:0] B_frac,
   output logic        busy,
   output logic        done,
   output logic        sign,
   output logic [7:0]  exp,
   output logic [23:0] frac,
   output logic        error,
   output logic        overflow,
   output logic        div_by_zero
);

   localparam logic [7:0] EXP_ALL1 = EXP_MAX[7:0];
   localparam logic [4:0] LAST_STEP = 5'd24;   // 25 quotient bits: steps 0..24

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_NORM = 2'd2
   } state_t;

   // Outcome of a special-operand op, decided once at the start edge.
   typedef enum logic [2:0] {
      SP_NONE = 3'd0,
      SP_NAN  = 3'd1,
      SP_INF  = 3'd2,
      SP_DBZ  = 3'd3,
      SP_ZERO = 3'd4
   } spec_t;

   state_t      state_q, state_d;
   spec_t       spec_q,  spec_d;
   logic [4:0]  cnt_q;
   logic [25:0] rem_q;
   logic [24:0] quo_q;
   logic [23:0] dvs_q;
   logic [7:0]  a_exp_q, b_exp_q;
   logic        sgn_q;

   logic        done_q,  done_d;
   logic        sign_q,  sign_d;
   logic [7:0]  exp_q,   exp_d;
   logic [23:0] frac_q,  frac_d;
   logic        error_q, error_d;
   logic        ovf_q,   ovf_d;
   logic        dbz_q,   dbz_d;

   // ---------------------------------------------------------------
   // Operand classification (live inputs, used only at the start edge)
   // ---------------------------------------------------------------
   logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

   always_comb begin
      // exp==0 covers denormals as well: they are treated as zero.
      a_zero = (A_exp == 8'd0);
      b_zero = (B_exp == 8'd0);
      a_inf  = (A_exp == EXP_ALL1) && (A_frac == 23'd0);
      b_inf  = (B_exp == EXP_ALL1) && (B_frac == 23'd0);
      a_nan  = (A_exp == EXP_ALL1) && (A_frac != 23'd0);
      b_nan  = (B_exp == EXP_ALL1) && (B_frac != 23'd0);
   end

   always_comb begin
      spec_d = SP_NONE;
      if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
         spec_d = SP_NAN;
      end else if (a_inf) begin
         spec_d = SP_INF;
      end else if (b_zero) begin
         spec_d = SP_DBZ;
      end else if (a_zero || b_inf) begin
         spec_d = SP_ZERO;
      end
   end

   // ---------------------------------------------------------------
   // Restoring division step
   // ---------------------------------------------------------------
   logic        rem_ge;
   logic [25:0] rem_sub;
   logic [25:0] rem_step;

   always_comb begin
      rem_ge   = (rem_q >= {2'b00, dvs_q});
      rem_sub  = rem_ge ? (rem_q - {2'b00, dvs_q}) : rem_q;
      // rem_sub < divisor < 2^24, so the shift never loses a bit.
      rem_step = rem_sub << 1;
   end

   // ---------------------------------------------------------------
   // Normalisation and exponent
   // ---------------------------------------------------------------
   logic              adj;
   logic [23:0]       frac_n;
   logic signed [9:0] e_norm;

   always_comb begin
      // Quotient lies in [0.5,2): at most one left shift normalises it.
      adj    = ~quo_q[24];
      frac_n = quo_q[24] ? quo_q[24:1] : quo_q[23:0];
      e_norm = $signed({2'b00, a_exp_q}) - $signed({2'b00, b_exp_q})
             + $signed(EXP_BIAS[9:0]) - $signed({9'd0, adj});
   end

   // ---------------------------------------------------------------
   // FSM next state
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = (spec_d == SP_NONE) ? S_DIV : S_NORM;
            end
         end
         S_DIV: begin
            if (cnt_q == LAST_STEP) begin
               state_d = S_NORM;
            end
         end
         S_NORM: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Result selection (registered only on the NORM -> IDLE edge)
   // ---------------------------------------------------------------
   always_comb begin
      sign_d  = sgn_q;
      exp_d   = 8'd0;
      frac_d  = 24'd0;
      error_d = 1'b0;
      ovf_d   = 1'b0;
      dbz_d   = 1'b0;
      case (spec_q)
         SP_NAN: begin
            exp_d   = EXP_ALL1;
            frac_d  = 24'h800000;
            error_d = 1'b1;
         end
         SP_INF: begin
            exp_d = EXP_ALL1;
         end
         SP_DBZ: begin
            exp_d = EXP_ALL1;
            dbz_d = 1'b1;
         end
         SP_ZERO: begin
            exp_d = 8'd0;
         end
         default: begin
            if (e_norm >= 10'sd255) begin
               exp_d = EXP_ALL1;
               ovf_d = 1'b1;
            end else if (e_norm <= 10'sd0) begin
               // Underflow flushes to zero without a flag.
               exp_d = 8'd0;
            end else begin
               exp_d  = e_norm[7:0];
               frac_d = frac_n;
            end
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         spec_q  <= SP_NONE;
         cnt_q   <= 5'd0;
         rem_q   <= 26'd0;
         quo_q   <= 25'd0;
         dvs_q   <= 24'd0;
         a_exp_q <= 8'd0;
         b_exp_q <= 8'd0;
         sgn_q   <= 1'b0;
         done_q  <= 1'b0;
         sign_q  <= 1'b0;
         exp_q   <= 8'd0;
         frac_q  <= 24'd0;
         error_q <= 1'b0;
         ovf_q   <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;

         if (state_q == S_IDLE && start) begin
            spec_q  <= spec_d;
            cnt_q   <= 5'd0;
            rem_q   <= {3'b001, A_frac};
            quo_q   <= 25'd0;
            dvs_q   <= {1'b1, B_frac};
            a_exp_q <= A_exp;
            b_exp_q <= B_exp;
            sgn_q   <= A_sign ^ B_sign;
         end

         if (state_q == S_DIV) begin
            rem_q <= rem_step;
            quo_q <= {quo_q[23:0], rem_ge};
            cnt_q <= cnt_q + 5'd1;
         end

         if (state_q == S_NORM) begin
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            frac_q  <= frac_d;
            error_q <= error_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
         end
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign sign        = sign_q;
   assign exp         = exp_q;
   assign frac        = frac_q;
   assign error       = error_q;
   assign overflow    = ovf_q;
   assign div_by_zero = dbz_q;

endmodule
